// File: rtl/guess_leds_core.sv
// LED memory game: flashes an LFSR-picked pattern, scores the switch guess, adapts show time to win streaks.
// Presses act one CLK after the synchroniser edge; every timer steps only on TICK; no backpressure.
module guess_leds_core #(
  parameter int N_LEDS      = 16,
  parameter int NUM_PICKS   = 5,
  parameter int TICK_DIV    = 2_000_000,
  parameter int SHOW_TICKS  = 8,
  parameter int GUESS_TICKS = 500,
  parameter int REVEAL_OK   = 48,
  parameter int REVEAL_BAD  = 96,
  parameter int MAX_ROUNDS  = 8,
  parameter int MAX_LEVEL   = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              KEY_N,
  input  logic [N_LEDS-1:0] SW,
  output logic [N_LEDS-1:0] LEDS,
  output logic [5:0]        MODE,
  output logic [3:0]        ROUNDS,
  output logic [3:0]        ROUNDS_OK,
  output logic [5:0]        HITS,
  output logic [1:0]        LEVEL,
  output logic              TICK
);
  localparam int W      = $clog2(N_LEDS);
  localparam int CW     = $clog2(TICK_DIV);
  localparam int TMAX_A = (GUESS_TICKS > REVEAL_BAD) ? GUESS_TICKS : REVEAL_BAD;
  localparam int TMAX_B = (REVEAL_OK > SHOW_TICKS) ? REVEAL_OK : SHOW_TICKS;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = ($clog2(TMAX + 1) < 3) ? 3 : $clog2(TMAX + 1);

  localparam logic [31:0] LFSR_SEED = 32'hACE12345;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_SHOW   = 6'b000010,
    S_GUESS  = 6'b000100,
    S_EVAL   = 6'b001000,
    S_REVEAL = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     tick_cnt_q;
  logic [31:0]       lfsr_q;
  logic [31:0]       lfsr_d;
  logic              key_s1_q, key_s2_q, key_prev_q;
  logic              press;
  logic [N_LEDS-1:0] pattern_q;
  logic [N_LEDS-1:0] leds_q;
  logic [N_LEDS-1:0] pick_pat;
  logic [W-1:0]      pick;
  logic [TW-1:0]     timer_q;
  logic [TW-1:0]     show_len;
  logic [3:0]        rounds_q, ok_q;
  logic [5:0]        hits_q, hits_calc;
  logic [1:0]        level_q, streak_q;

  assign TICK = (tick_cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      key_prev_q <= 1'b1;
    end else begin
      tick_cnt_q <= TICK ? '0 : tick_cnt_q + CW'(1);
      lfsr_q     <= lfsr_d;
      key_s1_q   <= KEY_N;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
  assign press  = key_prev_q & ~key_s2_q;

  // Picks beyond bit 31 wrap around the LFSR so wide/many-pick configurations stay defined.
  always_comb begin
    pick_pat = '0;
    pick     = '0;
    for (int i = 0; i < NUM_PICKS; i++) begin
      for (int b = 0; b < W; b++) pick[b] = lfsr_q[(i * W + b) % 32];
      pick_pat[pick] = 1'b1;
    end
  end

  always_comb begin
    show_len = TW'(SHOW_TICKS >> level_q);
    if (show_len == '0) show_len = TW'(1);
  end

  always_comb begin
    hits_calc = '0;
    for (int i = 0; i < N_LEDS; i++) hits_calc = hits_calc + 6'(SW[i] & pattern_q[i]);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      leds_q    <= '0;
      pattern_q <= '0;
      timer_q   <= '0;
      rounds_q  <= '0;
      ok_q      <= '0;
      hits_q    <= '0;
      level_q   <= '0;
      streak_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          leds_q <= '0;
          if (press) begin
            pattern_q <= pick_pat;
            leds_q    <= pick_pat;
            timer_q   <= show_len;
            state_q   <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (TICK) begin
            if (timer_q == TW'(1)) begin
              leds_q  <= '0;
              timer_q <= TW'(GUESS_TICKS);
              state_q <= S_GUESS;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
        end
        S_GUESS: begin
          if (press || (TICK && timer_q == '0)) state_q <= S_EVAL;
          else if (TICK)                        timer_q <= timer_q - TW'(1);
        end
        S_EVAL: begin
          hits_q   <= hits_calc;
          rounds_q <= rounds_q + 4'd1;
          if (SW == pattern_q) begin
            ok_q    <= ok_q + 4'd1;
            timer_q <= TW'(REVEAL_OK);
            // Second consecutive win bumps the level and restarts the streak.
            if (streak_q == 2'd1) begin
              streak_q <= '0;
              if (level_q != 2'(MAX_LEVEL)) level_q <= level_q + 2'd1;
            end else begin
              streak_q <= streak_q + 2'd1;
            end
          end else begin
            streak_q <= '0;
            timer_q  <= TW'(REVEAL_BAD);
            if (level_q != '0) level_q <= level_q - 2'd1;
          end
          state_q <= S_REVEAL;
        end
        S_REVEAL: begin
          leds_q <= timer_q[2] ? pattern_q : '0;
          if (TICK) begin
            if (timer_q == '0) begin
              if (rounds_q == 4'(MAX_ROUNDS)) begin
                leds_q  <= N_LEDS'(1);
                state_q <= S_DONE;
              end else begin
                leds_q  <= '0;
                state_q <= S_IDLE;
              end
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
        end
        S_DONE: begin
          if (TICK) leds_q <= {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign LEDS      = leds_q;
  assign MODE      = state_q;
  assign ROUNDS    = rounds_q;
  assign ROUNDS_OK = ok_q;
  assign HITS      = hits_q;
  assign LEVEL     = level_q;
endmodule

// File: tb/tb_guess_leds_core.sv
// Bench for guess_leds_core: plays a full 12-round game against a scoreboard, then the end effect and resets.
module tb_guess_leds_core;
  localparam int N    = 16;
  localparam int NP   = 5;
  localparam int TD   = 4;
  localparam int SHOW = 8;
  localparam int GUESS = 500;
  localparam int ROK  = 48;
  localparam int RBAD = 96;
  localparam int MAXR = 12;
  localparam int MAXL = 3;

  localparam logic [5:0] M_IDLE   = 6'b000001;
  localparam logic [5:0] M_SHOW   = 6'b000010;
  localparam logic [5:0] M_GUESS  = 6'b000100;
  localparam logic [5:0] M_REVEAL = 6'b010000;
  localparam logic [5:0] M_DONE   = 6'b100000;

  typedef struct {
    int rounds;
    int ok;
    int hits;
    int level;
  } exp_t;
  exp_t sb[$];

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         KEY_N = 1'b1;
  logic [N-1:0] SW = '0;
  logic [N-1:0] LEDS;
  logic [5:0]   MODE;
  logic [3:0]   ROUNDS, ROUNDS_OK;
  logic [5:0]   HITS;
  logic [1:0]   LEVEL;
  logic         TICK;

  int n_cmp = 0;
  int n_fail = 0;
  int m_rounds = 0, m_ok = 0, m_level = 0, m_streak = 0;
  logic [31:0] m_lfsr, m_lfsr_prev;

  guess_leds_core #(
    .N_LEDS(N), .NUM_PICKS(NP), .TICK_DIV(TD), .SHOW_TICKS(SHOW), .GUESS_TICKS(GUESS),
    .REVEAL_OK(ROK), .REVEAL_BAD(RBAD), .MAX_ROUNDS(MAXR), .MAX_LEVEL(MAXL)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY_N(KEY_N), .SW(SW), .LEDS(LEDS), .MODE(MODE),
    .ROUNDS(ROUNDS), .ROUNDS_OK(ROUNDS_OK), .HITS(HITS), .LEVEL(LEVEL), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  // Reference random source: m_lfsr_prev is the value the DUT saw on the most recent edge.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_lfsr      <= 32'hACE12345;
      m_lfsr_prev <= 32'hACE12345;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
    end
  end

  function automatic logic [N-1:0] pat_of(input logic [31:0] l);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < NP; i++) p[l[i*4 +: 4]] = 1'b1;
    return p;
  endfunction

  task automatic wait_mode(input logic [5:0] m, input int budget, output bit ok);
    int c;
    c = 0;
    while (MODE !== m && c < budget) begin
      @(negedge CLK);
      c++;
    end
    ok = (MODE === m);
  endtask

  task automatic play_round(input int kind, input string tag);
    bit ok, bad_leds, saw_pat;
    logic [N-1:0] pat, sw_v;
    int ticks, cyc, exp_show, exp_rev;
    exp_t e, g;
    @(negedge CLK);
    wait_mode(M_IDLE, 2000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL %s idle_wait: MODE=%b want %b", tag, MODE, M_IDLE); end
    exp_show = ((SHOW >> m_level) < 1) ? 1 : (SHOW >> m_level);
    KEY_N = 1'b0;
    cyc = 0;
    while (MODE !== M_SHOW && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    pat = pat_of(m_lfsr_prev);
    KEY_N = 1'b1;
    n_cmp++;
    if (MODE !== M_SHOW) begin n_fail++; $display("FAIL %s show_entry: MODE=%b want %b", tag, MODE, M_SHOW); end
    n_cmp++;
    if (LEDS !== pat) begin n_fail++; $display("FAIL %s show_leds: LEDS=%h want %h", tag, LEDS, pat); end
    ticks = 0;
    cyc = 0;
    while (MODE === M_SHOW && cyc < 4000) begin
      if (TICK) ticks++;
      @(negedge CLK);
      cyc++;
    end
    n_cmp++;
    if (ticks != exp_show || MODE !== M_GUESS) begin
      n_fail++;
      $display("FAIL %s show_len: ticks=%0d MODE=%b want ticks=%0d MODE=%b", tag, ticks, MODE, exp_show, M_GUESS);
    end
    n_cmp++;
    if (LEDS !== '0) begin n_fail++; $display("FAIL %s guess_leds: LEDS=%h want 0", tag, LEDS); end

    if (kind == 0)      sw_v = pat;
    else if (kind == 1) sw_v = pat & ~(pat & (~pat + 1'b1));
    else                sw_v = '0;
    SW = sw_v;
    e.hits = $countones(sw_v & pat);
    m_rounds++;
    if (sw_v == pat) begin
      m_ok++;
      m_streak++;
      if (m_streak == 2) begin
        m_streak = 0;
        if (m_level < MAXL) m_level++;
      end
    end else begin
      m_streak = 0;
      if (m_level > 0) m_level--;
    end
    e.rounds = m_rounds;
    e.ok     = m_ok;
    e.level  = m_level;
    sb.push_back(e);

    if (kind != 2) begin
      KEY_N = 1'b0;
      cyc = 0;
      while (MODE !== M_REVEAL && cyc < 40) begin
        @(negedge CLK);
        cyc++;
      end
      KEY_N = 1'b1;
    end else begin
      ticks = 0;
      cyc = 0;
      while (MODE === M_GUESS && cyc < 4 * (GUESS + 20)) begin
        if (TICK) ticks++;
        @(negedge CLK);
        cyc++;
      end
      n_cmp++;
      if (ticks < GUESS || ticks > GUESS + 1) begin
        n_fail++;
        $display("FAIL %s guess_timeout: ticks=%0d want %0d..%0d", tag, ticks, GUESS, GUESS + 1);
      end
      wait_mode(M_REVEAL, 4, ok);
    end
    n_cmp++;
    if (MODE !== M_REVEAL) begin n_fail++; $display("FAIL %s reveal_entry: MODE=%b want %b", tag, MODE, M_REVEAL); end

    g = sb.pop_front();
    n_cmp++;
    if (ROUNDS !== 4'(g.rounds)) begin n_fail++; $display("FAIL %s rounds: got %0d want %0d", tag, ROUNDS, g.rounds); end
    n_cmp++;
    if (ROUNDS_OK !== 4'(g.ok)) begin n_fail++; $display("FAIL %s rounds_ok: got %0d want %0d", tag, ROUNDS_OK, g.ok); end
    n_cmp++;
    if (HITS !== 6'(g.hits)) begin n_fail++; $display("FAIL %s hits: got %0d want %0d", tag, HITS, g.hits); end
    n_cmp++;
    if (LEVEL !== 2'(g.level)) begin n_fail++; $display("FAIL %s level: got %0d want %0d", tag, LEVEL, g.level); end

    ticks = 0;
    cyc = 0;
    bad_leds = 1'b0;
    saw_pat = 1'b0;
    while (MODE === M_REVEAL && cyc < 4 * (RBAD + 20)) begin
      if (TICK) ticks++;
      if (LEDS === pat) saw_pat = 1'b1;
      else if (LEDS !== '0) bad_leds = 1'b1;
      @(negedge CLK);
      cyc++;
    end
    exp_rev = (sw_v == pat) ? ROK : RBAD;
    n_cmp++;
    if (ticks < exp_rev || ticks > exp_rev + 1) begin
      n_fail++;
      $display("FAIL %s reveal_len: ticks=%0d want %0d..%0d", tag, ticks, exp_rev, exp_rev + 1);
    end
    n_cmp++;
    if (bad_leds || !saw_pat) begin
      n_fail++;
      $display("FAIL %s reveal_leds: stray=%0b blinked=%0b want stray=0 blinked=1", tag, bad_leds, saw_pat);
    end
    n_cmp++;
    if (MODE !== ((m_rounds == MAXR) ? M_DONE : M_IDLE)) begin
      n_fail++;
      $display("FAIL %s after_reveal: MODE=%b want %b", tag, MODE, (m_rounds == MAXR) ? M_DONE : M_IDLE);
    end
  endtask

  task automatic test_reset();
    int tick_at[$];
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    n_cmp++;
    if (MODE !== M_IDLE || LEDS !== '0) begin
      n_fail++; $display("FAIL reset_mode_leds: MODE=%b LEDS=%h want %b 0", MODE, LEDS, M_IDLE);
    end
    n_cmp++;
    if (ROUNDS !== 4'd0 || ROUNDS_OK !== 4'd0 || HITS !== 6'd0 || LEVEL !== 2'd0) begin
      n_fail++; $display("FAIL reset_counters: %0d %0d %0d %0d want 0 0 0 0", ROUNDS, ROUNDS_OK, HITS, LEVEL);
    end
    for (int c = 0; c < 16; c++) begin
      if (TICK) tick_at.push_back(c);
      @(negedge CLK);
    end
    n_cmp++;
    if (tick_at.size() != 4) begin
      n_fail++; $display("FAIL tick_count: got %0d want 4", tick_at.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (tick_at[k] != 3 + 4 * k) begin
          n_fail++; $display("FAIL tick_phase: pulse %0d at %0d want %0d", k, tick_at[k], 3 + 4 * k);
        end
      end
    end
  endtask

  task automatic test_exact();
    play_round(0, "exact");
  endtask

  task automatic test_partial();
    play_round(1, "partial");
  endtask

  task automatic test_timeout();
    play_round(2, "timeout");
  endtask

  task automatic test_difficulty();
    for (int r = 0; r < 8; r++) play_round(0, "difficulty");
  endtask

  task automatic test_end_of_game();
    bit ok;
    logic [N-1:0] one, want;
    play_round(1, "last");
    one = 1;
    n_cmp++;
    if (LEDS !== one) begin n_fail++; $display("FAIL done_first: LEDS=%h want %h", LEDS, one); end
    for (int k = 1; k <= 16; k++) begin
      wait_mode(M_DONE, 1, ok);
      begin
        int c;
        c = 0;
        while (!TICK && c < 10) begin @(negedge CLK); c++; end
      end
      @(negedge CLK);
      want = one << (k % 16);
      n_cmp++;
      if (LEDS !== want) begin n_fail++; $display("FAIL done_rotate %0d: LEDS=%h want %h", k, LEDS, want); end
    end
    KEY_N = 1'b0;
    repeat (8) @(negedge CLK);
    KEY_N = 1'b1;
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (MODE !== M_DONE) begin n_fail++; $display("FAIL done_key_ignored: MODE=%b want %b", MODE, M_DONE); end
  endtask

  task automatic test_reset_mid_show();
    bit ok;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_cmp++;
    if (MODE !== M_IDLE || LEDS !== '0 || ROUNDS !== 4'd0) begin
      n_fail++; $display("FAIL reset_from_done: MODE=%b LEDS=%h ROUNDS=%0d want %b 0 0", MODE, LEDS, ROUNDS, M_IDLE);
    end
    m_rounds = 0; m_ok = 0; m_level = 0; m_streak = 0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    KEY_N = 1'b0;
    wait_mode(M_SHOW, 20, ok);
    KEY_N = 1'b1;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL midshow_entry: MODE=%b want %b", MODE, M_SHOW); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    n_cmp++;
    if (MODE !== M_IDLE || LEDS !== '0) begin
      n_fail++; $display("FAIL midshow_reset: MODE=%b LEDS=%h want %b 0", MODE, LEDS, M_IDLE);
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_partial();
    test_timeout();
    test_difficulty();
    test_end_of_game();
    test_reset_mid_show();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/guess_leds_core.md
Name: guess_leds_core

Overview:
- Parametrised next-generation "guess the LEDs" game engine.
- Flashes a random pattern of NUM_PICKS positions on an N_LEDS-wide LED bar and waits for the player to enter a guess on switches. The guess is submitted with an active-low key.
- Adds an internal tick divider, an LFSR random source, adaptive difficulty (the show time shrinks as the player keeps winning) and a partial-credit hit count.
- Sits between the board pins and the score/7-segment decoders in the top level.

Parameters:
- N_LEDS, 16: LED/switch width; power of 2, 4..32.
- NUM_PICKS, 5: random positions ORed into a pattern, 1..8.
- TICK_DIV, 2_000_000: CLK cycles per game tick, >=2.
- SHOW_TICKS, 8: pattern display time at level 0, in ticks, >=1.
- GUESS_TICKS, 500: guess timeout, in ticks.
- REVEAL_OK, 48: reveal duration after a correct guess, in ticks.
- REVEAL_BAD, 96: reveal duration after a wrong guess, in ticks.
- MAX_ROUNDS, 8: rounds per game, 1..15.
- MAX_LEVEL, 3: highest difficulty level.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- KEY_N  in  1  guess/start button, active-low, asynchronous to CLK.
- SW  in  N_LEDS  player guess.
- LEDS  out  N_LEDS  pattern / reveal / end effect.
- MODE  out  6  one-hot state: bit0 IDLE, bit1 SHOW, bit2 GUESS, bit3 EVAL, bit4 REVEAL, bit5 DONE.
- ROUNDS  out  4  rounds played.
- ROUNDS_OK  out  4  rounds guessed exactly.
- HITS  out  6  count of set bits in (SW & pattern) at the last evaluation.
- LEVEL  out  2  current difficulty level.
- TICK  out  1  one-CLK tick pulse, for debug.

Behaviour:
- Reset (RST low, asynchronous)
  - State IDLE.
  - LEDS, ROUNDS, ROUNDS_OK, HITS, LEVEL, tick counter and streak counter = 0; MODE = 6'b000001.
  - LFSR = 32'hACE12345.
  - Synchroniser flops = 1, so no false press is detected on release.
  - Reset asserted mid-game aborts immediately, in any state.
- Tick divider
  - Counts 0..TICK_DIV-1.
  - TICK is high for one CLK when count == TICK_DIV-1, then the counter wraps to 0.
- LFSR
  - 32-bit Galois, mask 32'h80200003, shifts every CLK.
  - Never zero.
- Key handling
  - KEY_N passes through a 2-flop synchroniser.
  - A press is the falling edge of the synchronised signal: a 1-CLK pulse, acted on without waiting for TICK.
- Pattern
  - On a press in IDLE, the pattern is captured from the LFSR.
  - Pick i uses LFSR bits [i*W +: W], W = log2(N_LEDS).
  - pattern = OR of (1 << pick_i), giving 1..NUM_PICKS bits set.
  - Pattern is held until the next capture.
- show_len = max(1, SHOW_TICKS >> LEVEL), computed at capture.
- State machine: presses are handled on CLK; every timer decrements only on TICK.
  - IDLE: on press, capture the pattern, load timer = show_len, go to SHOW. LEDS = 0.
  - SHOW: LEDS = pattern. On a TICK with timer == 1, set LEDS = 0, load GUESS_TICKS, go to GUESS. Otherwise decrement on TICK. Presses are ignored.
  - GUESS: on press, or on a TICK with timer == 0, go to EVAL. A press and a timeout in the same CLK count as a single EVAL.
  - EVAL (exactly 1 CLK, no TICK needed):
    - HITS = popcount(SW & pattern), zero-extended.
    - If SW == pattern: ROUNDS_OK+1, streak+1, timer = REVEAL_OK.
    - Otherwise: streak = 0, LEVEL = LEVEL-1 saturating at 0, timer = REVEAL_BAD.
    - When streak reaches 2: LEVEL = LEVEL+1 saturating at MAX_LEVEL, streak = 0.
    - ROUNDS+1. Go to REVEAL.
  - REVEAL:
    - LEDS = pattern when timer[2] is 1, else 0.
    - On a TICK with timer == 0: go to DONE with LEDS = 1 if ROUNDS == MAX_ROUNDS, else go to IDLE with LEDS = 0. Otherwise decrement on TICK.
  - DONE: on each TICK, LEDS rotates left by 1 (MSB wraps to LSB). Only reset exits this state.
- Counters are 4 bits. MAX_ROUNDS <= 15 guarantees no wrap.

Test Plan:
- Reset check: TICK_DIV=4. Release RST -> TICK pulses every 4th CLK; MODE=000001; LEDS, ROUNDS, ROUNDS_OK and HITS all 0.
- Exact guess: TICK_DIV=4, SHOW_TICKS=8. Press KEY_N; mirror the captured pattern on SW; press again in GUESS -> SHOW lasts 8 ticks; ROUNDS=1, ROUNDS_OK=1, HITS=popcount(pattern); REVEAL lasts 48 ticks, then IDLE.
- Partial guess: set SW = pattern with one set bit cleared; press -> ROUNDS_OK unchanged, HITS=popcount-1, REVEAL lasts 96 ticks, LEVEL decremented (saturating at 0).
- Timeout: leave SW=0 and never press -> GUESS times out after 500 ticks, EVAL runs with HITS=0, ROUNDS increments.
- Difficulty: win 6 rounds in a row -> LEVEL goes 0,1,2,3, then saturates at 3; SHOW shrinks 8, 4, 2, 1 ticks.
- End of game: MAX_ROUNDS=2. Play two rounds -> DONE with LEDS=0001, then 0002, 0004 on successive ticks; bit N_LEDS-1 wraps to bit 0; KEY_N is ignored. Pulling RST low mid-SHOW gives IDLE, LEDS=0 asynchronously.
